// File: rtl/ddr4_cmd_scheduler_if.sv
// Request/command bundle between the two requesters, the scheduler and the
// DDR4 controller pins. The master side is the requester/controller
// environment and the slave side is the scheduler.
interface ddr4_cmd_scheduler_if #(
    parameter int ROW_W = 17,
    parameter int COL_W = 10
);
    localparam int ADDR_W = ROW_W + COL_W + 3;

    logic              req0_valid;
    logic              req1_valid;
    logic              req0_we;
    logic              req1_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [ADDR_W-1:0] req1_addr;
    logic [15:0]       req0_wdata;
    logic [15:0]       req1_wdata;
    logic              req0_ack;
    logic              req1_ack;
    logic              act_n;
    logic              ras_n;
    logic              cas_n;
    logic              we_n;
    logic              bg;
    logic [1:0]        ba;
    logic [ROW_W-1:0]  addr;
    logic              refresh;
    logic [15:0]       wdata;
    logic              busy;

    modport master (
        output req0_valid, req1_valid, req0_we, req1_we,
               req0_addr, req1_addr, req0_wdata, req1_wdata,
        input  req0_ack, req1_ack, act_n, ras_n, cas_n, we_n,
               bg, ba, addr, refresh, wdata, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_we, req1_we,
               req0_addr, req1_addr, req0_wdata, req1_wdata,
        output req0_ack, req1_ack, act_n, ras_n, cas_n, we_n,
               bg, ba, addr, refresh, wdata, busy
    );
endinterface

// File: rtl/ddr4_cmd_scheduler.sv
// Two-port round-robin DDR4 command scheduler: tracks the open row per bank
// ({bg,ba}) and sequences ACT/PRE/RD/WR plus periodic PREA/REF with
// tRCD/tRP/tRFC spacing. Command pins are decoded from the current state.
module ddr4_cmd_scheduler #(
    parameter int ROW_W  = 17,
    parameter int COL_W  = 10,
    parameter int T_RCD  = 4,
    parameter int T_RP   = 4,
    parameter int T_RFC  = 32,
    parameter int T_REFI = 1560
) (
    input logic                clk,
    input logic                reset_n,
    ddr4_cmd_scheduler_if.slave bus
);
    localparam int ADDR_W = ROW_W + COL_W + 3;
    localparam int T_MAX  = (T_RFC > T_RP) ? ((T_RFC > T_RCD) ? T_RFC : T_RCD)
                                           : ((T_RP > T_RCD) ? T_RP : T_RCD);
    localparam int WAIT_W = (T_MAX > 2) ? $clog2(T_MAX) : 1;
    localparam int REF_W  = (T_REFI > 2) ? $clog2(T_REFI) : 1;
    localparam logic [REF_W-1:0] REFI_LAST = REF_W'(T_REFI - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_TRP, S_ACT, S_TRCD, S_RW, S_PREA, S_TRPA, S_REF, S_TRFC
    } state_t;

    state_t              state, state_nxt;
    logic [7:0]          open_vld;
    logic [ROW_W-1:0]    open_row [8];
    logic [REF_W-1:0]    ref_cnt;
    logic                ref_pending;
    logic                ref_wrap;
    logic                rr;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                wait_load;
    logic [WAIT_W-1:0]   wait_val;

    logic                lat_win;
    logic                lat_we;
    logic [2:0]          lat_bank;
    logic [ROW_W-1:0]    lat_row;
    logic [COL_W-1:0]    lat_col;
    logic [15:0]         lat_wdata;

    logic                any_req;
    logic                pick;
    logic [ADDR_W-1:0]   sel_addr;
    logic [2:0]          sel_bank;
    logic [ROW_W-1:0]    sel_row;
    logic                sel_open;
    logic                sel_hit;

    assign any_req  = bus.req0_valid | bus.req1_valid;
    // Port 1 wins when it is the only requester or when both ask and rr favours it.
    assign pick     = bus.req1_valid & (~bus.req0_valid | rr);
    assign sel_addr = pick ? bus.req1_addr : bus.req0_addr;
    assign sel_bank = sel_addr[ADDR_W-1 -: 3];
    assign sel_row  = sel_addr[COL_W +: ROW_W];
    assign sel_open = open_vld[sel_bank];
    assign sel_hit  = sel_open && (open_row[sel_bank] == sel_row);
    assign ref_wrap = (ref_cnt == REFI_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state selection and wait-counter reload on entry to a timing state.
    always_comb begin
        state_nxt = state;
        wait_load = 1'b0;
        wait_val  = '0;
        case (state)
            S_IDLE: begin
                if (ref_pending)  state_nxt = (|open_vld) ? S_PREA : S_REF;
                else if (any_req) state_nxt = sel_hit ? S_RW : (sel_open ? S_PRE : S_ACT);
            end
            S_PRE: begin
                if (T_RP > 1) begin
                    state_nxt = S_TRP;
                    wait_load = 1'b1;
                    wait_val  = WAIT_W'(T_RP - 2);
                end else state_nxt = S_ACT;
            end
            S_TRP:  if (wait_cnt == '0) state_nxt = S_ACT;
            S_ACT: begin
                if (T_RCD > 1) begin
                    state_nxt = S_TRCD;
                    wait_load = 1'b1;
                    wait_val  = WAIT_W'(T_RCD - 2);
                end else state_nxt = S_RW;
            end
            S_TRCD: if (wait_cnt == '0) state_nxt = S_RW;
            S_RW:   state_nxt = S_IDLE;
            S_PREA: begin
                if (T_RP > 1) begin
                    state_nxt = S_TRPA;
                    wait_load = 1'b1;
                    wait_val  = WAIT_W'(T_RP - 2);
                end else state_nxt = S_REF;
            end
            S_TRPA: if (wait_cnt == '0) state_nxt = S_REF;
            S_REF: begin
                if (T_RFC > 1) begin
                    state_nxt = S_TRFC;
                    wait_load = 1'b1;
                    wait_val  = WAIT_W'(T_RFC - 2);
                end else state_nxt = S_IDLE;
            end
            S_TRFC: if (wait_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command pin decode from the current state and latched request.
    always_comb begin
        bus.act_n    = 1'b1;
        bus.ras_n    = 1'b1;
        bus.cas_n    = 1'b1;
        bus.we_n     = 1'b1;
        bus.refresh  = 1'b0;
        bus.addr     = '0;
        bus.bg       = lat_bank[2];
        bus.ba       = lat_bank[1:0];
        bus.wdata    = lat_wdata;
        bus.req0_ack = 1'b0;
        bus.req1_ack = 1'b0;
        bus.busy     = (state != S_IDLE);
        case (state)
            S_ACT: begin
                bus.act_n = 1'b0;
                bus.addr  = lat_row;
            end
            S_PRE, S_PREA: begin
                bus.ras_n    = 1'b0;
                bus.we_n     = 1'b0;
                bus.addr[10] = (state == S_PREA);
            end
            S_RW: begin
                bus.cas_n              = 1'b0;
                bus.we_n               = ~lat_we;
                bus.addr[COL_W-1:0]    = lat_col;
                bus.req0_ack           = ~lat_win;
                bus.req1_ack           = lat_win;
            end
            S_REF: begin
                bus.ras_n   = 1'b0;
                bus.cas_n   = 1'b0;
                bus.refresh = 1'b1;
            end
            default: ;
        endcase
    end

    // Shared down-counter for the tRP/tRCD/tRFC holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               wait_cnt <= '0;
        else if (wait_load)         wait_cnt <= wait_val;
        else if (wait_cnt != '0)    wait_cnt <= wait_cnt - 1'b1;
    end

    // Refresh interval timer; a wrap while already pending is absorbed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            if (ref_wrap)            ref_pending <= 1'b1;
            else if (state == S_REF) ref_pending <= 1'b0;
        end
    end

    // Capture the arbitration winner in IDLE and rotate priority on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_win   <= 1'b0;
            lat_we    <= 1'b0;
            lat_bank  <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
            lat_wdata <= '0;
            rr        <= 1'b0;
        end else begin
            if (state == S_IDLE && !ref_pending && any_req) begin
                lat_win   <= pick;
                lat_we    <= pick ? bus.req1_we : bus.req0_we;
                lat_bank  <= sel_bank;
                lat_row   <= sel_row;
                lat_col   <= sel_addr[COL_W-1:0];
                lat_wdata <= pick ? bus.req1_wdata : bus.req0_wdata;
            end
            if (state == S_RW) rr <= ~lat_win;
        end
    end

    // Open-row table: ACT opens the latched bank, PREA closes everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_vld <= '0;
            for (int unsigned i = 0; i < 8; i++) open_row[i] <= '0;
        end else if (state == S_ACT) begin
            open_vld[lat_bank] <= 1'b1;
            open_row[lat_bank] <= lat_row;
        end else if (state == S_PREA) begin
            open_vld <= '0;
        end
    end
endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Directed bench for ddr4_cmd_scheduler with a refresh interval of 200 cycles.
// Expected RD/WR completions are queued when a request is driven and checked
// whenever the scheduler acknowledges.
module tb_ddr4_cmd_scheduler;
    localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                           C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6, C_BAD = 3'd7;

    typedef struct {
        int          port;
        logic        we;
        logic        bg;
        logic [1:0]  ba;
        logic [16:0] addr;
        logic [15:0] wdata;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    exp_t sb[$];

    ddr4_cmd_scheduler_if #(.ROW_W(17), .COL_W(10)) ifc ();

    ddr4_cmd_scheduler #(
        .ROW_W(17), .COL_W(10), .T_RCD(4), .T_RP(4), .T_RFC(32), .T_REFI(200)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycles since reset release: value k right after the k-th rising edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [2:0] cmd_of();
        if (!ifc.act_n) return ifc.refresh ? C_BAD : C_ACT;
        case ({ifc.ras_n, ifc.cas_n, ifc.we_n, ifc.refresh})
            4'b1110: return C_NOP;
            4'b1010: return C_RD;
            4'b1000: return C_WR;
            4'b0100: return ifc.addr[10] ? C_PREA : C_PRE;
            4'b0011: return C_REF;
            default: return C_BAD;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input int p, input logic we, input logic bg, input logic [1:0] ba,
                         input logic [16:0] row, input logic [9:0] col,
                         input logic [15:0] d, input bit push);
        logic [29:0] a;
        exp_t        e;
        a = {bg, ba, row, col};
        if (p == 0) begin
            ifc.req0_valid = 1'b1; ifc.req0_we = we; ifc.req0_addr = a; ifc.req0_wdata = d;
        end else begin
            ifc.req1_valid = 1'b1; ifc.req1_we = we; ifc.req1_addr = a; ifc.req1_wdata = d;
        end
        if (push) begin
            e.port = p; e.we = we; e.bg = bg; e.ba = ba;
            e.addr = {7'b0, col}; e.wdata = d;
            sb.push_back(e);
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) ifc.req0_valid = 1'b0;
        else        ifc.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        steps(3);
        reset_n = 1'b1;
    endtask

    // Scoreboard: every RD/WR or ack must match the oldest expected completion.
    always @(negedge clk) begin
        if (reset_n && (ifc.req0_ack || ifc.req1_ack || cmd_of() == C_RD || cmd_of() == C_WR)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", {30'd0, ifc.req1_ack, ifc.req0_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ack_port", {30'd0, ifc.req1_ack, ifc.req0_ack}, (e.port == 1) ? 32'd2 : 32'd1);
                chk("sb_cmd", cmd_of(), e.we ? C_WR : C_RD);
                chk("sb_bank", {ifc.bg, ifc.ba}, {e.bg, e.ba});
                chk("sb_col", ifc.addr, e.addr);
                if (e.we) chk("sb_wdata", ifc.wdata, e.wdata);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
        ifc.req0_we = 1'b0;    ifc.req1_we = 1'b0;
        ifc.req0_addr = '0;    ifc.req1_addr = '0;
        ifc.req0_wdata = '0;   ifc.req1_wdata = '0;

        // Reset state
        repeat (10) @(posedge clk);
        #1;
        chk("rst_cmd", cmd_of(), C_NOP);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_ack", {ifc.req1_ack, ifc.req0_ack}, 0);
        chk("rst_bus", {ifc.bg, ifc.ba, ifc.addr, ifc.wdata}, 0);
        reset_n = 1'b1;

        // Quiet until the first refresh interval expires
        while (cyc < 200) begin
            chk("quiet", {cmd_of(), ifc.busy}, {C_NOP, 1'b0});
            step();
        end
        chk("ref_decide", cmd_of(), C_NOP);
        step();
        chk("ref_closed", cmd_of(), C_REF);
        chk("ref_pin", ifc.refresh, 1);
        while (cyc < 232) step();
        chk("trfc_busy", {cmd_of(), ifc.busy}, {C_NOP, 1'b1});
        step();
        chk("trfc_done", ifc.busy, 0);

        // Closed-bank write then row hit
        drive(0, 1'b1, 1'b0, 2'd0, 17'd2, 10'd0, 16'hff00, 1'b1);
        step();
        chk("t2_act", cmd_of(), C_ACT);
        chk("t2_act_row", ifc.addr, 2);
        steps(3);
        chk("t2_trcd", cmd_of(), C_NOP);
        step();
        chk("t2_wr", cmd_of(), C_WR);
        drop(0);
        step();
        drive(0, 1'b1, 1'b0, 2'd0, 17'd2, 10'd4, 16'h1234, 1'b1);
        step();
        chk("t2_hit_wr", cmd_of(), C_WR);
        drop(0);
        step();

        // Other bank group miss, then row conflict
        drive(1, 1'b0, 1'b1, 2'd0, 17'd2, 10'd3, 16'h0000, 1'b1);
        step();
        chk("t3_act", cmd_of(), C_ACT);
        chk("t3_act_bg", {ifc.bg, ifc.ba, ifc.addr}, {1'b1, 2'd0, 17'd2});
        steps(4);
        chk("t3_rd", cmd_of(), C_RD);
        drop(1);
        step();
        drive(0, 1'b0, 1'b0, 2'd0, 17'd7, 10'd5, 16'h0000, 1'b1);
        step();
        chk("t3_pre", cmd_of(), C_PRE);
        steps(4);
        chk("t3_act7", cmd_of(), C_ACT);
        chk("t3_act7_row", ifc.addr, 7);
        steps(4);
        chk("t3_rd7", cmd_of(), C_RD);
        drop(0);
        step();
        drive(1, 1'b0, 1'b1, 2'd0, 17'd2, 10'd6, 16'h0000, 1'b1);
        step();
        chk("t3_hit1", cmd_of(), C_RD);
        drop(1);
        step();

        // Both ports hitting continuously: grants alternate starting at port 0
        drive(0, 1'b1, 1'b0, 2'd0, 17'd7, 10'd8, 16'ha5a5, 1'b1);
        drive(1, 1'b0, 1'b1, 2'd0, 17'd2, 10'd9, 16'h0000, 1'b1);
        drive(0, 1'b1, 1'b0, 2'd0, 17'd7, 10'd8, 16'ha5a5, 1'b1);
        drive(1, 1'b0, 1'b1, 2'd0, 17'd2, 10'd9, 16'h0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_rw", cmd_of(), (k % 2 == 0) ? C_WR : C_RD);
            if (k == 3) begin
                drop(0);
                drop(1);
            end
            step();
        end

        // Fresh reset: port 0 wins a tie, then refresh lands inside tRCD
        do_reset();
        drive(0, 1'b1, 1'b0, 2'd0, 17'd2, 10'd1, 16'hbeef, 1'b1);
        drive(1, 1'b0, 1'b1, 2'd1, 17'd3, 10'd2, 16'h0000, 1'b1);
        step();
        chk("rr_act0", {cmd_of(), ifc.bg, ifc.addr}, {C_ACT, 1'b0, 17'd2});
        steps(4);
        chk("rr_wr0", cmd_of(), C_WR);
        drop(0);
        steps(2);
        chk("rr_act1", {cmd_of(), ifc.bg, ifc.ba, ifc.addr}, {C_ACT, 1'b1, 2'd1, 17'd3});
        steps(4);
        chk("rr_rd1", cmd_of(), C_RD);
        drop(1);
        while (cyc < 197) step();
        drive(0, 1'b0, 1'b0, 2'd1, 17'd5, 10'd3, 16'h0000, 1'b1);
        step();
        chk("t5_act", cmd_of(), C_ACT);
        steps(4);
        chk("t5_rd", cmd_of(), C_RD);
        drop(0);
        step();
        chk("t5_decide", ifc.busy, 0);
        step();
        chk("t5_prea", cmd_of(), C_PREA);
        drive(0, 1'b0, 1'b0, 2'd0, 17'd2, 10'd7, 16'h0000, 1'b1);
        steps(4);
        chk("t5_ref", cmd_of(), C_REF);
        while (cyc < 240) step();
        chk("t5_idle", ifc.busy, 0);
        step();
        chk("t5_miss_act", {cmd_of(), ifc.addr}, {C_ACT, 17'd2});
        steps(4);
        chk("t5_miss_rd", cmd_of(), C_RD);
        drop(0);
        step();

        // Reset during tRP of a conflict aborts without an ack
        drive(1, 1'b0, 1'b0, 2'd0, 17'd9, 10'd0, 16'h0000, 1'b0);
        step();
        chk("t6_pre", cmd_of(), C_PRE);
        step();
        chk("t6_trp", {cmd_of(), ifc.busy}, {C_NOP, 1'b1});
        reset_n = 1'b0;
        #1;
        chk("t6_abort", {cmd_of(), ifc.busy, ifc.req1_ack, ifc.req0_ack}, {C_NOP, 3'b000});
        drop(1);
        steps(3);
        reset_n = 1'b1;
        drive(1, 1'b0, 1'b0, 2'd0, 17'd9, 10'd0, 16'h0000, 1'b1);
        step();
        chk("t6_act", {cmd_of(), ifc.addr}, {C_ACT, 17'd9});
        steps(4);
        chk("t6_rd", cmd_of(), C_RD);
        drop(1);
        steps(2);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
